// File: rtl/dave_pkg.sv
// Shared constants for the Dave interrupt controller: channel indices,
// default I/O port and status/control bit-position helpers.
package dave_pkg;

    localparam int NCH     = 4;
    localparam int CH_TONE = 0;
    localparam int CH_SEC  = 1;
    localparam int CH_VID  = 2;
    localparam int CH_EXT  = 3;

    localparam logic [7:0] PORT_DEFAULT = 8'hB4;

    // Control byte: even bit enables a channel, odd bit clears its latch.
    // Status byte: even bit is the source level, odd bit the latch.
    function automatic int en_pos(input int c);
        return 2 * c;
    endfunction

    function automatic int clr_pos(input int c);
        return 2 * c + 1;
    endfunction

    function automatic int src_pos(input int c);
        return 2 * c;
    endfunction

    function automatic int lat_pos(input int c);
        return 2 * c + 1;
    endfunction

endpackage

// File: rtl/edge_latch.sv
// One interrupt channel: samples its source, detects a 1->0 transition
// and holds a sticky latch with set-over-clear priority.
module edge_latch
    import dave_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic src_i,
    input  logic clr_i,
    output logic smp_o,
    output logic lat_o
);

    logic smp_q;
    logic hist_q;
    logic lat_q;
    logic lat_d;
    logic fall;

    // History and sample preset high so leaving reset never fakes an edge.
    assign fall = hist_q & ~smp_q;

    always_comb begin
        lat_d = lat_q;
        if (fall) begin
            lat_d = 1'b1;
        end else if (clr_i) begin
            lat_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_q  <= 1'b1;
            hist_q <= 1'b1;
            lat_q  <= 1'b0;
        end else begin
            smp_q  <= src_i;
            hist_q <= smp_q;
            lat_q  <= lat_d;
        end
    end

    assign smp_o = smp_q;
    assign lat_o = lat_q;

endmodule

// File: rtl/dave_int.sv
// Dave interrupt controller: tone/1Hz/video/ext edge latches, port decode,
// status readback and active-low irq. Define DAVE_EXTINT_EN to build channel 3.
module dave_int
    import dave_pkg::*;
#(
    parameter int unsigned SECDIV = 4000000,
    parameter logic [7:0]  PORT   = PORT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pe,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    input  logic       tone,
    input  logic       vint,
    input  logic       ext,
    output logic       irq
);

`ifdef DAVE_EXTINT_EN
    localparam int NACT = NCH;
`else
    localparam int NACT = NCH - 1;
`endif
    localparam int DW = 2 * NACT;
    localparam logic [23:0] CNT_LAST = 24'(SECDIV - 1);
    localparam logic [23:0] CNT_HALF = 24'(SECDIV / 2);

    logic [23:0]     cnt_q, cnt_d;
    logic            sec_src;
    logic [NACT-1:0] src_raw, src_s, lat, clr;
    logic [NACT-1:0] en_q, en_d;
    logic [NCH-1:0]  src_all, lat_all;
    logic            wr_hit, rd_hit;
    logic            wr_seen_q, wr_seen_d;
    logic            wr_stb_q, wr_stb_d;
    logic [DW-1:0]   wr_dat_q;
    logic [7:0]      q_q, q_d;
    logic            irq_q, irq_d;

    assign cnt_d   = !pe ? cnt_q : (cnt_q == CNT_LAST) ? 24'd0 : cnt_q + 24'd1;
    assign sec_src = (cnt_q < CNT_HALF);

    assign src_raw[CH_TONE] = tone;
    assign src_raw[CH_SEC]  = sec_src;
    assign src_raw[CH_VID]  = vint;

`ifdef DAVE_EXTINT_EN
    logic [1:0] ext_sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_sync_q <= 2'b11;
        end else begin
            ext_sync_q <= {ext_sync_q[0], ext};
        end
    end

    assign src_raw[CH_EXT] = ext_sync_q[1];
`else
    logic [2:0] unused_ext;
    assign unused_ext = {ext, d[7:6]};
`endif

    for (genvar c = 0; c < NACT; c++) begin : g_ch
        edge_latch u_latch (
            .clock (clock),
            .reset (reset),
            .src_i (src_raw[c]),
            .clr_i (clr[c]),
            .smp_o (src_s[c]),
            .lat_o (lat[c])
        );
    end

    // A held write sees several pe strobes; only the first one acts.
    assign wr_hit    = pe & ~iorq & ~wr & (a == PORT);
    assign rd_hit    = pe & ~iorq & ~rd & (a == PORT);
    assign wr_seen_d = pe ? wr_hit : wr_seen_q;
    assign wr_stb_d  = wr_hit & ~wr_seen_q;

    always_comb begin
        en_d = en_q;
        clr  = '0;
        if (wr_stb_q) begin
            for (int c = 0; c < NACT; c++) begin
                en_d[c] = wr_dat_q[en_pos(c)];
                clr[c]  = wr_dat_q[clr_pos(c)];
            end
        end
    end

    assign src_all = NCH'(src_s);
    assign lat_all = NCH'(lat);

    always_comb begin
        q_d = q_q;
        if (rd_hit) begin
            for (int c = 0; c < NCH; c++) begin
                q_d[src_pos(c)] = src_all[c];
                q_d[lat_pos(c)] = lat_all[c];
            end
        end
    end

    assign irq_d = ~|(lat & en_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= 24'd0;
            wr_seen_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            en_q      <= '0;
            q_q       <= 8'hFF;
            irq_q     <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            wr_seen_q <= wr_seen_d;
            wr_stb_q  <= wr_stb_d;
            en_q      <= en_d;
            q_q       <= q_d;
            irq_q     <= irq_d;
        end
    end

    // Write data rides alongside wr_stb_q; it needs no reset.
    always_ff @(posedge clock) begin
        wr_dat_q <= d[DW-1:0];
    end

    assign q   = q_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_dave_int.sv
// Directed bench for dave_int with a short 1 Hz divider (SECDIV=10).
module tb_dave_int;

    logic       clock = 1'b0;
    logic       reset, pe, iorq, rd, wr, tone, vint, ext;
    logic [7:0] a, d, q;
    logic       irq;
    logic [7:0] r;
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         t1, t2;

`ifdef DAVE_EXTINT_EN
    localparam bit HAS_EXT = 1'b1;
`else
    localparam bit HAS_EXT = 1'b0;
`endif

    always #5 clock = ~clock;

    dave_int #(.SECDIV(10), .PORT(8'hB4)) dut (
        .clock (clock),
        .reset (reset),
        .pe    (pe),
        .iorq  (iorq),
        .rd    (rd),
        .wr    (wr),
        .a     (a),
        .d     (d),
        .q     (q),
        .tone  (tone),
        .vint  (vint),
        .ext   (ext),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic bus_wr(input logic [7:0] val);
        iorq = 1'b0; wr = 1'b0; a = 8'hB4; d = val;
        tick();
        iorq = 1'b1; wr = 1'b1; a = 8'h00;
    endtask

    task automatic wr_full(input logic [7:0] val);
        bus_wr(val);
        tick();
        tick();
    endtask

    task automatic bus_rd(output logic [7:0] val);
        iorq = 1'b0; rd = 1'b0; a = 8'hB4;
        tick();
        iorq = 1'b1; rd = 1'b1; a = 8'h00;
        val = q;
    endtask

    task automatic wait_irq_low(input string tag, output int t);
        t = -1;
        for (int i = 0; i < 30; i++) begin
            if (irq == 1'b0) begin
                t = cyc;
                break;
            end
            tick();
        end
        check(tag, (t >= 0), 1'b1);
    endtask

    initial begin
        reset = 1'b1; pe = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1;
        a = 8'h00; d = 8'h00; tone = 1'b1; vint = 1'b1; ext = 1'b1;
        repeat (3) tick();
        check("rst_irq", irq, 1'b1);
        check("rst_q", q, 8'hFF);
        reset = 1'b0;
        repeat (6) tick();
        check("idle_irq", irq, 1'b1);
        check("idle_q_hold", q, 8'hFF);
        bus_rd(r);
        check("idle_rd", r & 8'hF3, HAS_EXT ? 8'h51 : 8'h11);

        // video channel enabled, falling edge -> irq two clocks later
        wr_full(8'h10);
        check("vid_en_irq", irq, 1'b1);
        vint = 1'b0;
        tick();
        tick();
        check("vid_irq_n1", irq, 1'b1);
        tick();
        check("vid_irq_n2", irq, 1'b0);
        bus_rd(r);
        check("vid_rd", r[5:4], 2'b10);

        // clear latch
        bus_wr(8'h30);
        tick();
        check("clr_n1", irq, 1'b0);
        tick();
        check("clr_n2", irq, 1'b1);

        // new edge in the very cycle the clear lands: set wins
        vint = 1'b1;
        repeat (2) tick();
        vint = 1'b0;
        repeat (3) tick();
        check("vid2_irq", irq, 1'b0);
        vint = 1'b1;
        repeat (2) tick();
        vint = 1'b0;
        bus_wr(8'h30);
        repeat (3) tick();
        check("setwins_irq", irq, 1'b0);
        bus_rd(r);
        check("setwins_lat", r[5], 1'b1);
        wr_full(8'h30);
        check("setwins_clr", irq, 1'b1);
        vint = 1'b1;
        repeat (2) tick();

        // 1 Hz channel with SECDIV=10
        wr_full(8'h08);
        check("sec_off_irq", irq, 1'b1);
        wr_full(8'h04);
        wait_irq_low("sec_first", t1);
        wr_full(8'h0C);
        check("sec_clr_a", irq, 1'b1);
        wait_irq_low("sec_fall1", t1);
        wr_full(8'h0C);
        check("sec_clr_b", irq, 1'b1);
        wait_irq_low("sec_fall2", t2);
        check("sec_period", t2 - t1, 10);
        wr_full(8'h08);
        check("sec_off2", irq, 1'b1);

        // latch without enable, then enable afterwards
        tone = 1'b0;
        repeat (4) tick();
        check("tone_noen_irq", irq, 1'b1);
        bus_rd(r);
        check("tone_lat", r[1], 1'b1);
        bus_wr(8'h01);
        tick();
        check("tone_en_n1", irq, 1'b1);
        tick();
        check("tone_en_n2", irq, 1'b0);
        wr_full(8'h02);
        check("tone_clr", irq, 1'b1);
        tone = 1'b1;
        repeat (2) tick();

        // external channel
        ext = 1'b0;
        repeat (6) tick();
        wr_full(8'h40);
        check("ext_irq", irq, HAS_EXT ? 1'b0 : 1'b1);
        bus_rd(r);
        check("ext_rd", r[7:6], HAS_EXT ? 2'b10 : 2'b00);
        wr_full(8'hC0);
        check("ext_clr_irq", irq, 1'b1);
        bus_rd(r);
        check("ext_rd2", r[7:6], 2'b00);
        ext = 1'b1;
        repeat (4) tick();
        wr_full(8'h00);

        // held write across three pe pulses acts only once
        wr_full(8'h01);
        check("hold_pre", irq, 1'b1);
        pe = 1'b0; iorq = 1'b0; wr = 1'b0; a = 8'hB4; d = 8'h03;
        repeat (2) tick();
        pe = 1'b1;
        tick();
        pe = 1'b0;
        repeat (3) tick();
        tone = 1'b0;
        repeat (3) tick();
        check("hold_set", irq, 1'b0);
        pe = 1'b1;
        tick();
        pe = 1'b0;
        repeat (2) tick();
        pe = 1'b1;
        tick();
        pe = 1'b0;
        repeat (4) tick();
        check("hold_once", irq, 1'b0);
        iorq = 1'b1; wr = 1'b1; a = 8'h00; pe = 1'b1;
        repeat (2) tick();
        wr_full(8'h02);
        check("hold_clr", irq, 1'b1);
        tone = 1'b1;
        repeat (2) tick();

        // asynchronous reset while an interrupt is pending
        wr_full(8'h01);
        tone = 1'b0;
        repeat (3) tick();
        check("mid_irq", irq, 1'b0);
        tone = 1'b1;
        repeat (2) tick();
        #3 reset = 1'b1;
        #1;
        check("async_irq", irq, 1'b1);
        check("async_q", q, 8'hFF);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("post_rst_irq", irq, 1'b1);
        bus_rd(r);
        check("post_rst_rd", r & 8'hF3, HAS_EXT ? 8'h51 : 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dave_int.md
# dave_int

Interrupt controller for the Dave-compatible I/O chip. It sits between the peripheral tick sources and the T80 adapter: it latches edge events, decodes CPU I/O accesses to port 0xB4, drives the active-low `irq` into the CPU's INT_n, and returns status bytes on reads. It also generates the 1 Hz interrupt source from the CPU clock enable.

## Interface
Parameters:
- `SECDIV`, default 4000000: count of `pe` pulses per 1 Hz period. Legal range is 2..2^24-1.
- `PORT`, default 8'hB4: I/O port address.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pe`  in  1  CPU positive clock enable; the same strobe drives the T80 adapter.
- `iorq`  in  1  active-low, from CPU.
- `rd`  in  1  active-low, from CPU.
- `wr`  in  1  active-low, from CPU.
- `a`  in  8  CPU address A[7:0].
- `d`  in  8  CPU data out.
- `q`  out  8  read data, registered.
- `tone`  in  1  sound-generator interrupt source (level).
- `vint`  in  1  Nick video interrupt (level).
- `ext`  in  1  external interrupt (level, asynchronous).
- `irq`  out  1  active-low interrupt request to CPU INT_n.

## Operation
- Four channels, indexed c = 0..3: tone, 1 Hz, video, ext.
- Each channel has:
  - `en[c]`: an enable bit.
  - `lat[c]`: a latch bit.
  - a source level `src[c]`.
- Source conditioning:
  - `ext` passes through a 2-flop synchronizer.
  - `tone` and `vint` are sampled once per `clock`.
- Edge capture: `lat[c]` is set on a falling edge of `src[c]`, i.e. previous sample 1 and current sample 0. Latches are set regardless of `en`.
- 1 Hz divider:
  - A 24-bit counter increments on each `pe` and wraps to 0 at SECDIV-1.
  - `src[1]` is 1 while count < SECDIV/2 (integer division), else 0. This gives one falling edge per period.
- Write cycle:
  - Detected when `pe`=1, `iorq`=0, `wr`=0, `a`=PORT, and no write was detected on the previous `pe`. This makes it one action per bus cycle.
  - For each c: `en[c]` <= d[2c] and, if d[2c+1]=1, `lat[c]` is cleared.
- Read cycle:
  - Detected when `pe`=1, `iorq`=0, `rd`=0, `a`=PORT.
  - `q` <= {lat3,src3,lat2,src2,lat1,src1,lat0,src0}, i.e. bit 2c = `src[c]` and bit 2c+1 = `lat[c]`.
  - When no read is detected, `q` holds its value.
- Simultaneous events: a clear and a new edge on the same channel in the same clock leaves `lat`=1; the set wins so no event is lost.
- `irq` <= ~|(`lat` & `en`), registered.
- Reset (asynchronous): `en`=0, `lat`=0, edge history=1, divider=0, sync flops=1, `q`=8'hFF, `irq`=1.
- Reset mid-operation aborts any pending latch; after release the first cycle does not generate false edges, because history was preset to 1.

## Timing
- Source falling edge on `tone`/`vint` sampled at edge N: `lat` is set at N+1 and `irq` falls at N+2.
- `ext`: two extra cycles for the synchronizer, so `irq` falls at N+4.
- Write with clear at `pe` edge N: `lat` is cleared at N+1 and `irq` rises at N+2 if no other channel is pending.
- Enable takes effect the same way as clear, with `irq` following one clock later.
- `q` is valid the clock after the read-strobe edge and stays stable until the next read. The CPU samples it on a later `pe`.
- Repeated `pe` pulses within one held write produce only one update.

## Configuration
- `DAVE_EXTINT_EN` defined: channel 3 (`ext`) is fully implemented.
- `DAVE_EXTINT_EN` undefined:
  - `ext` is ignored and the synchronizer is not built.
  - `en[3]` and `lat[3]` are constant 0, and q[7:6] reads 2'b00.
  - d[7:6] writes have no effect.

## Structure
- Shared package `dave_pkg` holds:
  - channel index constants `CH_TONE`=0, `CH_SEC`=1, `CH_VID`=2, `CH_EXT`=3;
  - the default port constant 8'hB4;
  - bit-position helper constants for en/clear/src/lat.
- Sub-module `edge_latch` holds the per-channel history flop, latch, set-over-clear priority and asynchronous reset. It is instantiated 3 or 4 times.

## Test plan
- Reset then idle, with all sources high: `irq`=1, `q`=FF, and no latch set after reset release.
- Write 0xB4 with d=0x10, then pulse `vint` 1→0: `irq`=0 two clocks after the edge. A read gives q[5]=1 and q[4]=0.
- With `irq` low from video, write d=0x30: `irq`=1 two clocks later. A concurrent `vint` falling edge in the clear cycle keeps `lat`=1 and `irq`=0.
- SECDIV=10, write d=0x04: `irq` falls once every 10 `pe` pulses. It is cleared by writing d=0x0C.
- Latch without enable: `tone` edge with `en`=0 keeps `irq`=1. A read shows q[1]=1. A later write of d=0x01 drives `irq`=0.
- Macro undefined: toggling `ext` and writing d=0xC0 leaves `irq`=1, and reads show q[7:6]=00. Holding `wr` low across 3 `pe` pulses updates `en` only once.
